// File: rtl/simon_panel.sv
// Player-side front end for the Simon core: button conditioning and LED drive.
// Define SIMON_PANEL_GAMEOVER_BLINK_EN to blink all LEDs while gameOver is high.
module simon_panel #(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int ECHO_TICKS     = 15,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic [3:0] led
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] ECHO_INIT = CNT_W'(ECHO_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] echo_q, echo_d;
    logic [1:0]       cap_q, cap_d;
    logic [1:0]       num_q, num_d;
    logic             pulse_q, pulse_d;
    logic [3:0]       led_q, led_d;

    logic [3:0] s;
    logic       single;
    logic       locked;
    logic [1:0] idx;
    logic       s_any;
    logic       s_match;
    logic [3:0] go_led;

`ifdef SIMON_PANEL_GAMEOVER_BLINK_EN
    logic [5:0] blink_q, blink_d;

    // 60-cycle period: first 30 cycles lit, next 30 dark
    always_comb begin
        blink_d = '0;
        go_led  = 4'b0000;
        if (gameOver) begin
            go_led  = (blink_q < 6'd30) ? 4'b1111 : 4'b0000;
            blink_d = (blink_q == 6'd59) ? 6'd0 : blink_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    assign go_led = 4'b0000;
`endif

    always_comb begin
        s       = sync2_q;
        s_any   = (s != 4'b0000);
        locked  = simonTurn | gameOver;
        single  = 1'b1;
        idx     = 2'd0;
        case (s)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: single = 1'b0;
        endcase
        s_match = (s == (4'b0001 << cap_q));
    end

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        num_d   = num_q;
        pulse_d = 1'b0;
        echo_d  = (echo_q != '0) ? echo_q - CNT_ONE : echo_q;

        unique case (state_q)
            IDLE: begin
                if (s_any) begin
                    if (locked || !single) begin
                        state_d = HELD;
                    end else begin
                        cap_d   = idx;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (locked || !s_match) begin
                    state_d = s_any ? HELD : IDLE;
                end else if (cnt_q == DB_LAST) begin
                    num_d   = cap_q;
                    pulse_d = 1'b1;
                    echo_d  = ECHO_INIT;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s_any) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (s_any) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // No accept can occur while locked, so holding echo at 0 is safe
        if (simonTurn) begin
            echo_d = '0;
        end

        led_d = 4'b0000;
        if (gameOver) begin
            led_d = go_led;
        end else if (simonTurn && simonPressed) begin
            led_d = 4'b0001 << simonNum;
        end else if (echo_q != '0) begin
            led_d = 4'b0001 << num_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            echo_q  <= '0;
            cap_q   <= '0;
            num_q   <= '0;
            pulse_q <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            echo_q  <= echo_d;
            cap_q   <= cap_d;
            num_q   <= num_d;
            pulse_q <= pulse_d;
            led_q   <= led_d;
        end
    end

    assign playerNum     = num_q;
    assign playerPressed = pulse_q;
    assign led           = led_q;

endmodule
